// File: rtl/pq_ctrl_pkg.sv
// Shared types and helpers for the priority-queue access arbiter.
package pq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } op_t;

  // A push paired with a pop becomes a single replace on the queue.
  function automatic op_t op_from_grants(input logic push_g, input logic pop_g);
    op_t op;
    op = OP_NONE;
    if (push_g && pop_g) op = OP_REPL;
    else if (push_g)     op = OP_ENQ;
    else if (pop_g)      op = OP_DEQ;
    return op;
  endfunction

  function automatic logic op_writes(input op_t op);
    return (op == OP_ENQ) || (op == OP_REPL);
  endfunction

  function automatic logic op_reads(input op_t op);
    return (op == OP_DEQ) || (op == OP_REPL);
  endfunction

endpackage

// File: rtl/pq_access_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after the pointer wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan requesters in rotated order starting at the pointer.
  always_comb begin : pick
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pq_access_arbiter.sv
// Shares one priority queue between NUM_REQ requesters: round-robin push/pop
// arbitration, push+pop fused into replace, settle gap between operations.
module pq_access_arbiter
  import pq_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 1,
  localparam int IDW = $clog2(NUM_REQ),
  localparam int CW  = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_push_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_push_data,
  output logic [NUM_REQ-1:0]            o_push_ready,
  input  logic [NUM_REQ-1:0]            i_pop_valid,
  output logic [NUM_REQ-1:0]            o_pop_ready,
  output logic                          o_rsp_valid,
  output logic [IDW-1:0]                o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_err_zero,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_data
);

  state_t                  state_q, state_d;
  logic [CW-1:0]           settle_cnt;
  logic [IDW-1:0]          push_ptr, pop_ptr;

  logic [NUM_REQ-1:0]      push_gnt, pop_gnt, pop_req;
  logic [IDW-1:0]          push_idx, pop_idx;
  logic                    push_any, pop_any;
  logic                    idle_ok, push_take, pop_take, key_zero;
  logic signed [DATA_WIDTH-1:0] push_key;
  op_t                     op_d;

  // Latched operation (stage p0) and popped-head response (stage p1).
  op_t                     op_p0;
  logic                    zero_p0;
  logic signed [DATA_WIDTH-1:0] key_p0;
  logic [IDW-1:0]          pop_id_p0;
  logic                    vld_p1;
  logic [IDW-1:0]          rsp_id_p1;
  logic signed [DATA_WIDTH-1:0] rsp_data_p1;
  logic                    issuing;

  assign pop_req = i_pop_valid & {NUM_REQ{~i_q_empty}};

  rr_arbiter #(.N(NUM_REQ)) u_push_arb (
    .req(i_push_valid), .ptr(push_ptr), .gnt(push_gnt), .idx(push_idx), .any(push_any)
  );

  rr_arbiter #(.N(NUM_REQ)) u_pop_arb (
    .req(pop_req), .ptr(pop_ptr), .gnt(pop_gnt), .idx(pop_idx), .any(pop_any)
  );

  // Grants only in IDLE; reset overrides any same-cycle handshake.
  assign idle_ok   = (state_q == ST_IDLE) && !i_RST;
  assign pop_take  = idle_ok && pop_any;
  assign push_take = idle_ok && push_any && (!i_q_full || pop_any);

  assign o_push_ready = push_take ? push_gnt : '0;
  assign o_pop_ready  = pop_take  ? pop_gnt  : '0;

  assign push_key = i_push_data[int'(push_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign key_zero = (push_key == '0);
  // A zero key is handshaken but never reaches the queue.
  assign op_d     = op_from_grants(push_take && !key_zero, pop_take);

  // State register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> ISSUE on any grant, one ISSUE cycle, then settle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (push_take || pop_take) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt <= CW'(1)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Settle counter loads on ISSUE->SETTLE and counts down in SETTLE.
  always_ff @(posedge i_CLK) begin
    if (i_RST)                                     settle_cnt <= '0;
    else if (state_q == ST_ISSUE)                  settle_cnt <= CW'(SETTLE_CYCLES);
    else if (state_q == ST_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);
  end

  // Round-robin pointers advance past the winner only on a grant.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      push_ptr <= '0;
      pop_ptr  <= '0;
    end else begin
      if (push_take) push_ptr <= (push_idx == IDW'(NUM_REQ - 1)) ? '0 : push_idx + IDW'(1);
      if (pop_take)  pop_ptr  <= (pop_idx  == IDW'(NUM_REQ - 1)) ? '0 : pop_idx  + IDW'(1);
    end
  end

  // ---- stage p0: capture the granted operation while in IDLE ----
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      op_p0   <= OP_NONE;
      zero_p0 <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      op_p0   <= op_d;
      zero_p0 <= push_take && key_zero;
    end
  end

  // Key and pop id are data only; their use is gated by the latched op.
  always_ff @(posedge i_CLK) begin
    if (state_q == ST_IDLE) begin
      key_p0    <= push_take ? push_key : '0;
      pop_id_p0 <= pop_idx;
    end
  end

  assign issuing    = (state_q == ST_ISSUE);
  assign o_q_wrt    = issuing && op_writes(op_p0);
  assign o_q_read   = issuing && op_reads(op_p0);
  assign o_q_data   = issuing ? key_p0 : '0;
  assign o_err_zero = issuing && zero_p0;

  // ---- stage p1: head sampled at the ISSUE edge, before the queue updates ----
  always_ff @(posedge i_CLK) begin
    if (i_RST) vld_p1 <= 1'b0;
    else       vld_p1 <= o_q_read;
  end

  // Response payload; outputs are masked by the valid strobe.
  always_ff @(posedge i_CLK) begin
    if (o_q_read) begin
      rsp_data_p1 <= i_q_data;
      rsp_id_p1   <= pop_id_p0;
    end
  end

  assign o_rsp_valid = vld_p1;
  assign o_rsp_id    = vld_p1 ? rsp_id_p1   : '0;
  assign o_rsp_data  = vld_p1 ? rsp_data_p1 : '0;

endmodule

// File: tb/tb_pq_access_arbiter.sv
// Randomized bench for pq_access_arbiter with a behavioural queue and
// cycle-level reference model of the arbitration rules.
module tb_pq_access_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SC = 1;
  localparam int QS = 4;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      push_valid, pop_valid, push_ready, pop_ready;
  logic [N*DW-1:0]   push_data;
  logic              rsp_valid, err_zero, q_wrt, q_read, q_full, q_empty;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data, q_data, q_head;

  always #5 clk = ~clk;

  pq_access_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_push_valid(push_valid), .i_push_data(push_data), .o_push_ready(push_ready),
    .i_pop_valid(pop_valid), .o_pop_ready(pop_ready),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .o_err_zero(err_zero), .o_q_wrt(q_wrt), .o_q_read(q_read), .o_q_data(q_data),
    .i_q_full(q_full), .i_q_empty(q_empty), .i_q_data(q_head)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  // Behavioural priority queue: largest key is the head.
  int q[$];

  function automatic int head_idx();
    int h = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[h]) h = i;
    return h;
  endfunction

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // Reference model state
  int  m_push_ptr, m_pop_ptr, m_settle, m_key, m_pop_id, m_rsp_id, m_rsp_data;
  bit  m_issue, m_wr, m_rd, m_zero, m_rsp_v;
  // Next-state copies
  int  n_push_ptr, n_pop_ptr, n_settle, n_key, n_pop_id, n_rsp_id, n_rsp_data;
  bit  n_issue, n_wr, n_rd, n_zero, n_rsp_v;

  task automatic model_reset();
    m_push_ptr = 0; m_pop_ptr = 0; m_settle = 0; m_key = 0; m_pop_id = 0;
    m_rsp_id = 0; m_rsp_data = 0; m_issue = 0; m_wr = 0; m_rd = 0; m_zero = 0; m_rsp_v = 0;
  endtask

  task automatic drive_queue_status();
    q_full  = (q.size() >= QS);
    q_empty = (q.size() == 0);
    q_head  = (q.size() == 0) ? '0 : DW'(q[head_idx()]);
  endtask

  task automatic drive_inputs(input int cyc);
    int phase;
    phase = (cyc / 250) % 4;
    rst = (cyc > 20) && ($urandom_range(0, 79) == 0);
    for (int i = 0; i < N; i++) begin
      case (phase)
        0: begin push_valid[i] = ($urandom_range(0, 3) != 0); pop_valid[i] = ($urandom_range(0, 7) == 0); end
        1: begin push_valid[i] = ($urandom_range(0, 7) == 0); pop_valid[i] = ($urandom_range(0, 3) != 0); end
        default: begin push_valid[i] = $urandom_range(0, 1); pop_valid[i] = $urandom_range(0, 1); end
      endcase
      if (cyc < 14) begin push_valid[i] = 1'b0; pop_valid[i] = 1'b0; end
      if (phase == 3 && $urandom_range(0, 1) == 0) push_data[i*DW +: DW] = '0;
      else if ($urandom_range(0, 9) == 0)          push_data[i*DW +: DW] = '0;
      else                                         push_data[i*DW +: DW] = DW'($urandom_range(1, 16'hFFFF));
    end
  endtask

  initial begin
    int pw, pp, hi;
    bit idle;
    logic [N-1:0] ex_push, ex_pop;
    logic [N-1:0] pend_push_v;
    logic [N*DW-1:0] pend_data;

    rst = 1'b1; push_valid = '0; pop_valid = '0; push_data = '0;
    drive_queue_status();
    @(posedge clk); #1;
    model_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      // Inputs for this cycle (first cycles keep reset, then idle).
      if (cyc < 2) begin
        rst = 1'b1; push_valid = '0; pop_valid = '0;
      end else begin
        drive_inputs(cyc);
      end
      drive_queue_status();

      @(negedge clk);
      idle = !m_issue && (m_settle == 0);
      pw = -1; pp = -1;
      if (idle && !rst) begin
        if (q.size() != 0) pp = pick(pop_valid, m_pop_ptr);
        pw = pick(push_valid, m_push_ptr);
        if (pw >= 0 && q.size() >= QS && pp < 0) pw = -1;
      end
      ex_push = (pw >= 0) ? N'(1 << pw) : '0;
      ex_pop  = (pp >= 0) ? N'(1 << pp) : '0;

      chk("push_ready", 32'(push_ready), 32'(ex_push));
      chk("pop_ready",  32'(pop_ready),  32'(ex_pop));
      chk("q_wrt",      32'(q_wrt),      32'(m_issue && m_wr));
      chk("q_read",     32'(q_read),     32'(m_issue && m_rd));
      chk("q_data",     32'(q_data),     m_issue ? m_key : 0);
      chk("err_zero",   32'(err_zero),   32'(m_issue && m_zero));
      chk("rsp_valid",  32'(rsp_valid),  32'(m_rsp_v));
      chk("rsp_id",     32'(rsp_id),     m_rsp_v ? m_rsp_id : 0);
      chk("rsp_data",   32'(rsp_data),   m_rsp_v ? m_rsp_data : 0);

      // Next model state.
      n_push_ptr = m_push_ptr; n_pop_ptr = m_pop_ptr; n_settle = m_settle;
      n_key = m_key; n_pop_id = m_pop_id; n_issue = m_issue;
      n_wr = m_wr; n_rd = m_rd; n_zero = m_zero;
      n_rsp_v = m_issue && m_rd;
      n_rsp_id   = n_rsp_v ? m_pop_id : 0;
      n_rsp_data = (n_rsp_v && q.size() != 0) ? q[head_idx()] : 0;
      if (m_issue) begin
        n_issue = 0; n_settle = SC;
      end else if (m_settle > 0) begin
        n_settle = m_settle - 1;
      end else if (pw >= 0 || pp >= 0) begin
        n_issue  = 1;
        n_key    = (pw >= 0) ? int'(push_data[pw*DW +: DW]) : 0;
        n_zero   = (pw >= 0) && (n_key == 0);
        n_wr     = (pw >= 0) && (n_key != 0);
        n_rd     = (pp >= 0);
        n_pop_id = (pp >= 0) ? pp : 0;
        if (pw >= 0) n_push_ptr = (pw + 1) % N;
        if (pp >= 0) n_pop_ptr  = (pp + 1) % N;
      end

      @(posedge clk); #1;
      // The queue reacts to this cycle's strobes even if reset was asserted.
      if (m_issue && m_rd && q.size() != 0) begin
        hi = head_idx();
        q.delete(hi);
      end
      if (m_issue && m_wr && q.size() < QS) q.push_back(m_key);

      if (rst) begin
        model_reset();
      end else begin
        m_push_ptr = n_push_ptr; m_pop_ptr = n_pop_ptr; m_settle = n_settle;
        m_key = n_key; m_pop_id = n_pop_id; m_issue = n_issue;
        m_wr = n_wr; m_rd = n_rd; m_zero = n_zero;
        m_rsp_v = n_rsp_v; m_rsp_id = n_rsp_id; m_rsp_data = n_rsp_data;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pq_access_arbiter.md
# pq_access_arbiter

Front-end controller that shares one `register_array` priority queue (built with ENQ_ENA=1) between NUM_REQ requesters. It arbitrates push and pop requests round-robin and fuses a simultaneous push and pop into one replace operation. It drives the queue's write/read strobes, enforces a settle gap between operations, and returns popped heads tagged with the requester id. It sits between client engines and the queue instance.

## Interface
- NUM_REQ, default 4: number of requesters, at least 2.
- DATA_WIDTH, default 16: key width, matched to the queue.
- SETTLE_CYCLES, default 1: idle cycles after each queue operation before the next grant, at least 1.
- i_CLK  in  1  clock
- i_RST  in  1  reset; synchronous, active-high, one clock
- i_push_valid  in  NUM_REQ  per-requester push request
- i_push_data  in  NUM_REQ×DATA_WIDTH  per-requester key
- o_push_ready  out  NUM_REQ  one-hot push grant
- i_pop_valid  in  NUM_REQ  per-requester pop request
- o_pop_ready  out  NUM_REQ  one-hot pop grant
- o_rsp_valid  out  1  popped-head response strobe
- o_rsp_id  out  $clog2(NUM_REQ)  requester owning the response
- o_rsp_data  out  DATA_WIDTH  popped head value
- o_err_zero  out  1  one-cycle pulse: a zero key was accepted and dropped
- o_q_wrt, o_q_read  out  1 each  queue strobes
- o_q_data  out  DATA_WIDTH  key to the queue
- i_q_full, i_q_empty  in  1 each  queue status
- i_q_data  in  DATA_WIDTH  queue head

## Operation
- FSM states:
  - IDLE → ISSUE when at least one grant is made.
  - ISSUE → SETTLE after one cycle.
  - SETTLE → IDLE after SETTLE_CYCLES cycles.
- Grants are made only in IDLE. Push ready and pop ready are combinational from valid, state, status and the arbitration pointers.
- Push and pop each have an independent round-robin pointer. The winner is the first valid requester at or after the pointer. On a grant the pointer moves to winner+1 mod NUM_REQ; with no grant it holds.
- Grant rules in IDLE:
  - pop granted only if !i_q_empty;
  - push granted if !i_q_full, or if a pop is granted in the same cycle (replace);
  - both granted → replace;
  - push only → enqueue;
  - pop only → dequeue.
- Zero key: value 0 encodes an empty slot in the queue. A granted push with key 0 is accepted and handshaken but never issued; o_err_zero pulses in the ISSUE cycle.
  - Zero-key push with a pop grant → the operation degrades to a plain dequeue.
  - Zero-key push alone → ISSUE drives no strobes, and the FSM still passes through SETTLE.
- In ISSUE:
  - o_q_wrt and o_q_read are driven per the latched operation; o_q_data is the latched key.
  - For a pop, i_q_data is sampled (head before the update), together with the latched pop id.
- All outputs not driven by the current state are 0.

## Timing
- Handshake at edge t (IDLE) → queue strobes high for exactly the cycle t..t+1 → o_rsp_valid, o_rsp_id and o_rsp_data held for the single cycle after the ISSUE edge.
- Next grant is possible at the earliest in cycle t+2+SETTLE_CYCLES. Peak throughput is one operation per 2+SETTLE_CYCLES cycles.
- No backpressure on responses; o_rsp_valid is a single-cycle pulse.
- Reset values:
  - FSM=IDLE, pointers=0;
  - all ready, strobe, response and error outputs 0;
  - o_q_data=0, o_rsp_id=0.
- Reset mid-ISSUE or mid-SETTLE aborts the operation: no strobe or response on the following cycle. Reset wins over any same-cycle handshake.
- Status is sampled in IDLE only. i_q_full and i_q_empty are stable by then because of the settle gap.
- Requesters whose valid is low at the grant edge are skipped without a penalty.

## Structure
- Package pq_ctrl_pkg holds:
  - the state enum (ST_IDLE, ST_ISSUE, ST_SETTLE);
  - the operation enum (OP_NONE, OP_ENQ, OP_DEQ, OP_REPL);
  - a function mapping the push/pop grant pair to an operation.
- Sub-module rr_arbiter (parameter N): request vector plus pointer in, one-hot grant, index and any-grant out. It is instantiated twice, for push and pop.
- The settle counter is $clog2(SETTLE_CYCLES+1) bits and loads on ISSUE→SETTLE.

## Test plan
All scenarios use NUM_REQ=4, SETTLE_CYCLES=1, queue QUEUE_SIZE=4.
- Reset then idle: all outputs 0 for 10 cycles; first single push of 0x0005 from req2 → ready[2] at t, o_q_wrt in ISSUE, next push grant no earlier than t+3.
- Round-robin fairness: reqs 0–3 all push continuously with keys 1–4 → grant order 0,1,2,3, one grant every 3 cycles; fifth attempt blocked by i_q_full=1 with no ready.
- Pop with head 0x0009 from req3 → o_rsp_valid, o_rsp_id=3, o_rsp_data=0x0009 two cycles after the handshake; pop while i_q_empty=1 → never ready.
- Full queue, req1 push 0x0007 and req0 pop in the same cycle → replace: o_q_wrt=o_q_read=1 in one cycle, response carries the old head for id 0.
- Zero key: req2 pushes 0x0000 → ready[2]=1, o_err_zero pulse, no o_q_wrt; combined with a pop → dequeue only.
- Reset asserted during ISSUE → no response or strobe on the following cycle, FSM=IDLE, pointers=0.
